// File: rtl/pulse_stretcher.sv
// pulse_stretcher: replays each rising edge of pulse_in as a stretched output pulse.
// Each event drives led_out high for HIGH_TICKS tick_en periods, then low for GAP_TICKS
// periods. Events that arrive while a pulse is showing are queued in a saturating counter.
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   pulse_in  in   event input, synchronous to clk; one event per 0->1 transition
//   tick_en   in   one-clk-wide slow enable, timing base for the high and gap phases
//   led_out   out  stretched pulse output, registered
//   busy      out  high while showing a pulse or its trailing gap, registered
//   pending   out  queued events not yet started
//   overflow  out  sticky flag: an event was dropped because pending was saturated
module pulse_stretcher #(
  parameter int unsigned HIGH_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             tick_en,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int unsigned MaxTicks  = (HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS;
  localparam int unsigned TickRange = (MaxTicks < 2) ? 2 : MaxTicks;
  localparam int unsigned TW        = $clog2(TickRange);

  localparam logic [TW-1:0]    HighLast = TW'(HIGH_TICKS - 1);
  // Never compared when GAP_TICKS is zero; the guard only keeps the constant in range.
  localparam logic [TW-1:0]    GapLast  = TW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] PendMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    tick_q;
  logic             led_q;
  logic             busy_q;
  logic             pulse_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             req;
  logic             start;

  // History resets to 0, so a level already high at reset release counts as one event.
  assign req   = pulse_in & ~pulse_q;
  assign start = (state_q == StIdle) && (pending_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_in;
    end
  end

  // Pending queue: an event arriving on the same edge a pulse starts cancels the decrement.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (req && !start) begin
      if (pending_q == PendMax) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (!req && start) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Sequencer with registered led/busy outputs; tick_en is ignored while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StHigh;
            tick_q  <= '0;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StHigh: begin
          if (tick_en) begin
            if (tick_q == HighLast) begin
              tick_q <= '0;
              led_q  <= 1'b0;
              if (GAP_TICKS == 0) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                state_q <= StGap;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        StGap: begin
          if (tick_en) begin
            if (tick_q == GapLast) begin
              state_q <= StIdle;
              tick_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tick_q  <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
